windower_core: RTL and testbench

Streaming 1-D sliding-window generator for the convolution front end of the modulation-classification datapath. It accepts a sequence of 2^LOG2_IMG_SIZE samples, THROUGHPUT samples per valid beat; each sample is NO_CH bits wide with one bit per channel. For every input group it emits the THROUGHPUT+WINDOW-1 sample span that a downstream WINDOW-tap convolution needs to produce THROUGHPUT outputs. Out-of-range positions at both ends of the sequence are zero-padded.

---
 rtl/windower_core.sv | 117 +++++++++++
 tb/tb_windower_core.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/windower_core.sv
// Streaming 1-D sliding-window generator with zero padding at both sequence ends.
// Optional macro WINDOWER_LAST_EN adds last_out, flagging each image's flush window.
module windower_core #(
  parameter int NO_CH         = 16,
  parameter int LOG2_IMG_SIZE = 10,
  parameter int THROUGHPUT    = 1,
  parameter int WINDOW        = 3,
  parameter int PADDDING      = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vld_in,
  input  logic [NO_CH-1:0] data_in  [THROUGHPUT],
  output logic             vld_out,
  output logic [NO_CH-1:0] data_out [THROUGHPUT+WINDOW-1]
`ifdef WINDOWER_LAST_EN
  ,
  output logic             last_out
`endif
);

  localparam int SPAN   = THROUGHPUT + WINDOW - 1;
  localparam int LOG2_G = LOG2_IMG_SIZE - $clog2(THROUGHPUT);
  localparam int CW     = (LOG2_G > 0) ? LOG2_G : 1;
  localparam logic [CW-1:0] LAST_G = CW'((2 ** LOG2_G) - 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic             flush_q, flush_d;
  logic [NO_CH-1:0] prev_q [THROUGHPUT];
  logic [NO_CH-1:0] prev_d [THROUGHPUT];
  logic [NO_CH-1:0] cur_q  [THROUGHPUT];
  logic [NO_CH-1:0] cur_d  [THROUGHPUT];
  logic [NO_CH-1:0] win_q  [SPAN];
  logic [NO_CH-1:0] win_d  [SPAN];
  logic             vld_q, vld_d;
`ifdef WINDOWER_LAST_EN
  logic             last_q, last_d;
`endif

  logic isFirst, isLast, emitBeat;

  assign isFirst  = (cnt_q == '0);
  assign isLast   = (cnt_q == LAST_G);
  assign emitBeat = vld_in && !isFirst;

  // A window is emitted either by a non-first beat (right padding comes from the
  // incoming group) or by the pending flush (right padding forced to zero).
  // The two cannot coincide: the beat after the last one is always group 0.
  always_comb begin
    cnt_d   = cnt_q;
    flush_d = 1'b0;
    prev_d  = prev_q;
    cur_d   = cur_q;
    win_d   = win_q;
    vld_d   = 1'b0;
`ifdef WINDOWER_LAST_EN
    last_d  = 1'b0;
`endif
    if (flush_q || emitBeat) begin
      vld_d = 1'b1;
`ifdef WINDOWER_LAST_EN
      last_d = flush_q;
`endif
      for (int i = 0; i < PADDDING; i++) begin
        win_d[i]                     = prev_q[THROUGHPUT-PADDDING+i];
        win_d[PADDDING+THROUGHPUT+i] = emitBeat ? data_in[i] : '0;
      end
      for (int i = 0; i < THROUGHPUT; i++) begin
        win_d[PADDDING+i] = cur_q[i];
      end
    end
    if (vld_in) begin
      // Group 0 has nothing to its left, so prev is cleared rather than shifted.
      for (int i = 0; i < THROUGHPUT; i++) begin
        prev_d[i] = isFirst ? '0 : cur_q[i];
        cur_d[i]  = data_in[i];
      end
      cnt_d   = isLast ? '0 : cnt_q + CW'(1);
      flush_d = isLast;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      flush_q <= 1'b0;
      vld_q   <= 1'b0;
      for (int i = 0; i < THROUGHPUT; i++) begin
        prev_q[i] <= '0;
        cur_q[i]  <= '0;
      end
      for (int i = 0; i < SPAN; i++) begin
        win_q[i] <= '0;
      end
`ifdef WINDOWER_LAST_EN
      last_q  <= 1'b0;
`endif
    end else begin
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
      vld_q   <= vld_d;
      prev_q  <= prev_d;
      cur_q   <= cur_d;
      win_q   <= win_d;
`ifdef WINDOWER_LAST_EN
      last_q  <= last_d;
`endif
    end
  end

  assign vld_out  = vld_q;
  assign data_out = win_q;
`ifdef WINDOWER_LAST_EN
  assign last_out = last_q;
`endif

endmodule

// File: tb/tb_windower_core.sv
// Self-checking bench for windower_core: directed vector table, hand sequences and
// randomized streams scored against a position-based window model.
module tb_windower_core;

  localparam int NO_CH         = 16;
  localparam int LOG2_IMG_SIZE = 3;
  localparam int THROUGHPUT    = 1;
  localparam int WINDOW        = 3;
  localparam int PADDDING      = 1;
  localparam int SPAN          = THROUGHPUT + WINDOW - 1;
  localparam int N             = 2 ** LOG2_IMG_SIZE;

  typedef logic [SPAN-1:0][NO_CH-1:0] winT;

  logic             clk = 1'b0;
  logic             rst;
  logic             vld_in;
  logic [NO_CH-1:0] data_in  [THROUGHPUT];
  logic             vld_out;
  logic [NO_CH-1:0] data_out [SPAN];
`ifdef WINDOWER_LAST_EN
  logic             last_out;
`endif

  always #5 clk = ~clk;

  windower_core #(
    .NO_CH(NO_CH), .LOG2_IMG_SIZE(LOG2_IMG_SIZE), .THROUGHPUT(THROUGHPUT),
    .WINDOW(WINDOW), .PADDDING(PADDDING)
  ) dut (
    .clk(clk), .rst(rst), .vld_in(vld_in), .data_in(data_in),
    .vld_out(vld_out), .data_out(data_out)
`ifdef WINDOWER_LAST_EN
    , .last_out(last_out)
`endif
  );

  // Expected window, whether it is the flush window, and the cycle it must appear.
  typedef struct {
    winT  win;
    logic last;
    int   due;
  } expT;

  typedef struct {
    logic             r;
    logic             v;
    logic [NO_CH-1:0] d;
    logic             ev;
    winT              ew;
    logic             el;
  } vecT;

  expT              expQ [$];
  logic [NO_CH-1:0] img [N];
  int               pos;
  int               cycle;
  int               checks;
  int               errors;
  winT              heldWin;
  vecT              vecs [10];

  function automatic winT mkWin(input int a0, input int a1, input int a2);
    winT w;
    w[0] = NO_CH'(a0);
    w[1] = NO_CH'(a1);
    w[2] = NO_CH'(a2);
    return w;
  endfunction

  // Window of group g straight from its definition: positions g*T-P+i, zero outside 0..N-1.
  function automatic winT windowAt(input int g);
    winT w;
    for (int i = 0; i < SPAN; i++) begin
      int p;
      p = g * THROUGHPUT - PADDDING + i;
      w[i] = (p < 0 || p >= N) ? '0 : img[p];
    end
    return w;
  endfunction

  function automatic winT actualWin();
    winT w;
    for (int i = 0; i < SPAN; i++) w[i] = data_out[i];
    return w;
  endfunction

  task automatic modelEdge(input logic r, input logic v, input logic [NO_CH-1:0] d);
    if (r) begin
      expQ.delete();
      pos     = 0;
      heldWin = '0;
    end else if (v) begin
      img[pos] = d;
      if (pos >= 1) expQ.push_back('{windowAt(pos - 1), 1'b0, cycle});
      if (pos == N - 1) begin
        expQ.push_back('{windowAt(pos), 1'b1, cycle + 1});
        pos = 0;
      end else begin
        pos++;
      end
    end
  endtask

  task automatic applyStimulus(input logic r, input logic v, input logic [NO_CH-1:0] d);
    rst        = r;
    vld_in     = v;
    data_in[0] = d;
    @(posedge clk);
    cycle++;
    modelEdge(r, v, d);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag);
    logic expV;
    logic expL;
    winT  expW;
    winT  actW;
    expV = (expQ.size() > 0) && (expQ[0].due == cycle);
    expL = 1'b0;
    if (expV) begin
      expW    = expQ[0].win;
      expL    = expQ[0].last;
      heldWin = expW;
      void'(expQ.pop_front());
    end else begin
      expW = heldWin;
    end
    actW = actualWin();
    checks++;
    if (vld_out !== expV) begin
      errors++;
      $display("[TB] FAIL %s vld_out cycle %0d: got %0b want %0b", tag, cycle, vld_out, expV);
    end
    checks++;
    if (actW !== expW) begin
      errors++;
      $display("[TB] FAIL %s data_out cycle %0d: got %h want %h", tag, cycle, actW, expW);
    end
`ifdef WINDOWER_LAST_EN
    checks++;
    if (last_out !== expL) begin
      errors++;
      $display("[TB] FAIL %s last_out cycle %0d: got %0b want %0b", tag, cycle, last_out, expL);
    end
`endif
  endtask

  task automatic checkVector(input int k);
    checks++;
    if (vld_out !== vecs[k].ev || actualWin() !== vecs[k].ew) begin
      errors++;
      $display("[TB] FAIL vector%0d: got vld=%0b data=%h want vld=%0b data=%h",
               k, vld_out, actualWin(), vecs[k].ev, vecs[k].ew);
    end
`ifdef WINDOWER_LAST_EN
    checks++;
    if (last_out !== vecs[k].el) begin
      errors++;
      $display("[TB] FAIL vector%0d last_out: got %0b want %0b", k, last_out, vecs[k].el);
    end
`endif
  endtask

  task automatic sendSeq(input string tag, input int first, input int count);
    for (int i = 0; i < count; i++) begin
      applyStimulus(1'b0, 1'b1, NO_CH'(first + i));
      checkOutput(tag);
    end
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b0, NO_CH'($urandom));
      checkOutput(tag);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    cycle   = 0;
    pos     = 0;
    heldWin = '0;

    // Continuous stream 1..8 followed by the flush and one idle cycle.
    for (int k = 0; k < 8; k++) begin
      vecs[k] = '{1'b0, 1'b1, NO_CH'(k + 1), (k >= 1),
                  (k >= 1) ? mkWin(k - 1, k, k + 1) : mkWin(0, 0, 0), 1'b0};
    end
    vecs[8] = '{1'b0, 1'b0, '0, 1'b1, mkWin(7, 8, 0), 1'b1};
    vecs[9] = '{1'b0, 1'b0, '0, 1'b0, mkWin(7, 8, 0), 1'b0};

    rst        = 1'b1;
    vld_in     = 1'b0;
    data_in[0] = '0;

    // Reset held for 10 cycles with valid data offered, then released idle.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b1, NO_CH'($urandom));
      checkOutput("reset");
    end
    idle("post_reset", 3);

    for (int k = 0; k < 10; k++) begin
      applyStimulus(vecs[k].r, vecs[k].v, vecs[k].d);
      checkOutput("table");
      checkVector(k);
    end

    sendSeq("gap", 1, 4);
    idle("gap", 3);
    sendSeq("gap", 5, 4);
    idle("gap", 2);

    sendSeq("b2b", 1, 16);
    idle("b2b", 2);

    sendSeq("abort", 1, 5);
    applyStimulus(1'b1, 1'b0, '0);
    checkOutput("abort");
    sendSeq("abort", 1, 8);
    idle("abort", 3);

    // Randomized traffic: gaps, back-to-back images and occasional mid-stream resets.
    for (int i = 0; i < 800; i++) begin
      logic r;
      logic v;
      r = ($urandom_range(0, 79) == 0);
      v = ($urandom_range(0, 9) < 7);
      applyStimulus(r, v, NO_CH'($urandom));
      checkOutput("random");
    end
    idle("drain", 4);

    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d windows never produced, want 0", expQ.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
